// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver with PWM brightness and
// frame-synchronous double-buffered loads. Optional leading-zero blanking: SSD_LZB_EN.
module ssd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV_W    = 16,
  parameter int BRIGHT_W = 4
) (
  input  logic                  stateClk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     mode_in,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic                  ack,
  output logic                  frame_tick,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIGITS - 1);

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'b0000001;
      4'h1:    f = 7'b1001111;
      4'h2:    f = 7'b0010010;
      4'h3:    f = 7'b0000110;
      4'h4:    f = 7'b1001100;
      4'h5:    f = 7'b0100100;
      4'h6:    f = 7'b0100000;
      4'h7:    f = 7'b0001111;
      4'h8:    f = 7'b0000000;
      4'h9:    f = 7'b0000100;
      4'hA:    f = 7'b0001000;
      4'hB:    f = 7'b1100000;
      4'hC:    f = 7'b0110001;
      4'hD:    f = 7'b1000010;
      4'hE:    f = 7'b0110000;
      4'hF:    f = 7'b0111000;
      default: f = 7'b1111111;
    endcase
    return f;
  endfunction

  logic [DIV_W-1:0]    cnt_r;
  logic [SLOT_W-1:0]   slot_r;
  logic [4*DIGITS-1:0] stage_dig_r;
  logic [4*DIGITS-1:0] shad_dig_r;
  logic [DIGITS-1:0]   stage_dp_r;
  logic [DIGITS-1:0]   shad_dp_r;
  logic [DIGITS-1:0]   stage_mode_r;
  logic [DIGITS-1:0]   shad_mode_r;
  logic                pending_r;
  logic                ack_r;
  logic                frame_tick_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;

  logic                slot_edge_s;
  logic                frame_bnd_s;
  logic                commit_s;
  logic                on_s;
  logic                lit_s;
  logic [3:0]          cur_dig_s;
  logic [DIGITS-1:0]   blank_s;
  logic [DIGITS-1:0]   an_nxt_s;
  logic [6:0]          seg_nxt_s;
  logic                dp_nxt_s;

  assign slot_edge_s = &cnt_r;
  assign frame_bnd_s = slot_edge_s && (slot_r == LAST_SLOT);
  assign commit_s    = frame_bnd_s && (pending_r || load);
  assign on_s        = (&bright) || (cnt_r[DIV_W-1 -: BRIGHT_W] < bright);
  assign cur_dig_s   = shad_dig_r[{slot_r, 2'b00} +: 4];
  assign lit_s       = shad_mode_r[slot_r] && on_s;

`ifdef SSD_LZB_EN
  logic lzb_run_s;

  // Blank leading all-zero digits (value 0, no dp) from the top down; digit 0 always shows.
  always_comb begin
    blank_s   = '0;
    lzb_run_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lzb_run_s && (shad_dig_r[4*k +: 4] == 4'h0) && !shad_dp_r[k]) begin
        blank_s[k] = 1'b1;
      end else begin
        lzb_run_s = 1'b0;
      end
    end
  end
`else
  assign blank_s = '0;
`endif

  // Next display pattern; an unlit slot forces segments dark to avoid ghosting.
  always_comb begin
    an_nxt_s  = '1;
    seg_nxt_s = 7'h7F;
    dp_nxt_s  = 1'b1;
    if (lit_s) begin
      an_nxt_s[slot_r] = 1'b0;
      if (blank_s[slot_r]) begin
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
      end else begin
        seg_nxt_s = hex_font(cur_dig_s);
        dp_nxt_s  = ~shad_dp_r[slot_r];
      end
    end else begin
      an_nxt_s  = '1;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end
  end

  // Slot timebase: free-running divider and digit slot index.
  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      slot_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
      if (slot_edge_s) begin
        slot_r <= (slot_r == LAST_SLOT) ? '0 : slot_r + SLOT_W'(1);
      end
    end
  end

  // Staging/shadow buffers; a load on the boundary cycle bypasses straight to shadow.
  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      stage_dig_r  <= '0;
      stage_dp_r   <= '0;
      stage_mode_r <= '0;
      shad_dig_r   <= '0;
      shad_dp_r    <= '0;
      shad_mode_r  <= '0;
      pending_r    <= 1'b0;
      ack_r        <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      if (load) begin
        stage_dig_r  <= digits_in;
        stage_dp_r   <= dp_in;
        stage_mode_r <= mode_in;
      end
      if (commit_s) begin
        shad_dig_r  <= load ? digits_in : stage_dig_r;
        shad_dp_r   <= load ? dp_in     : stage_dp_r;
        shad_mode_r <= load ? mode_in   : stage_mode_r;
        pending_r   <= 1'b0;
      end else if (load) begin
        pending_r <= 1'b1;
      end
      ack_r        <= commit_s;
      frame_tick_r <= frame_bnd_s;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      an_r  <= '1;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign ack        = ack_r;
  assign frame_tick = frame_tick_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (DIGITS=4, DIV_W=4, BRIGHT_W=2).
module tb_ssd_scan_driver;

  localparam int DIGITS   = 4;
  localparam int DIV_W    = 4;
  localparam int BRIGHT_W = 2;

  logic        stateClk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  mode_in;
  logic [1:0]  bright;
  logic        load;
  logic        ack;
  logic        frame_tick;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int tests   = 0;
  int fails   = 0;
  int ack_cnt = 0;
  int lows[4];

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic [3:0]  mode;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  int         mon_k;
  logic       mon_blank;
  logic [6:0] mon_seg;
  logic       mon_dp;

  ssd_scan_driver #(.DIGITS(DIGITS), .DIV_W(DIV_W), .BRIGHT_W(BRIGHT_W)) dut (
    .stateClk   (stateClk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .mode_in    (mode_in),
    .bright     (bright),
    .load       (load),
    .ack        (ack),
    .frame_tick (frame_tick),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 stateClk = ~stateClk;

  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] t[16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[v];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge stateClk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m, input bit push);
    rec_t r;
    r.dig  = d;
    r.dpv  = p;
    r.mode = m;
    digits_in = d;
    dp_in     = p;
    mode_in   = m;
    load      = 1'b1;
    if (push) exp_q.push_back(r);
    @(negedge stateClk);
    load = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge stateClk);
      seen = ack;
    end
    check("ack_timeout", seen, 1);
  endtask

  task automatic wait_ft(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge stateClk);
      seen = frame_tick;
    end
    check("frame_tick_timeout", seen, 1);
  endtask

  task automatic count_frame();
    for (int k = 0; k < 4; k++) lows[k] = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge stateClk);
      for (int k = 0; k < 4; k++) if (!an[k]) lows[k]++;
    end
  endtask

  // Monitor: checks every displayed slot against the record made visible by the last ack.
  always @(negedge stateClk) begin
    if (rst) begin
      cur = '0;
    end else begin
      if (an != 4'hF) begin
        check("an_onehot", $countones(~an), 1);
        mon_k = 0;
        for (int j = 0; j < 4; j++) if (!an[j]) mon_k = j;
        check("an_enabled", cur.mode[mon_k], 1);
        mon_blank = 1'b0;
`ifdef SSD_LZB_EN
        if (mon_k != 0) begin
          mon_blank = 1'b1;
          for (int j = mon_k; j < 4; j++)
            if (cur.dig[4*j +: 4] != 4'h0 || cur.dpv[j]) mon_blank = 1'b0;
        end
`endif
        mon_seg = mon_blank ? 7'h7F : font(cur.dig[4*mon_k +: 4]);
        mon_dp  = mon_blank ? 1'b1 : ~cur.dpv[mon_k];
        check("mon_seg", seg, mon_seg);
        check("mon_dp", dp, mon_dp);
      end else begin
        check("dark_seg", seg, 7'h7F);
        check("dark_dp", dp, 1);
      end
      if (ack) begin
        ack_cnt++;
        check("ack_with_tick", frame_tick, 1);
        check("ack_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t1_an[4];
    logic [6:0] t1_seg[4];
    logic [6:0] t6_seg[4];
    t1_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    t1_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
`ifdef SSD_LZB_EN
    t6_seg = '{7'b0000001, 7'b0100100, 7'h7F, 7'h7F};
`else
    t6_seg = '{7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001};
`endif

    rst = 1'b1; digits_in = '0; dp_in = '0; mode_in = '0; bright = 2'd3; load = 1'b0;
    tick(3);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_ack", ack, 0);
    check("rst_tick", frame_tick, 0);
    rst = 1'b0;
    tick(2);
    check("post_rst_an", an, 4'hF);

    // First load and scan order
    do_load(16'h1234, 4'h0, 4'hF, 1'b1);
    wait_ack(200);
    check("t1_tick", frame_tick, 1);
    for (int s = 0; s < 4; s++) begin
      tick(1);
      check("t1_an_first", an, t1_an[s]);
      check("t1_seg_first", seg, t1_seg[s]);
      tick(15);
      check("t1_an_last", an, t1_an[s]);
      check("t1_seg_last", seg, t1_seg[s]);
    end
    check("t1_frame_period", frame_tick, 1);
    check("t1_no_ack", ack, 0);

    // Load in the boundary cycle (63 cycles after this frame_tick)
    tick(63);
    do_load(16'h9ABC, 4'h1, 4'hF, 1'b1);
    check("t2_ack", ack, 1);
    check("t2_old_an", an, 4'b0111);
    check("t2_old_seg", seg, 7'b1001111);
    tick(1);
    check("t2_new_an", an, 4'b1110);
    check("t2_new_seg", seg, 7'b0110001);
    check("t2_new_dp", dp, 0);

    // Double load within one frame
    tick(5);
    do_load(16'hAAAA, 4'h0, 4'hF, 1'b0);
    tick(10);
    do_load(16'hBBBB, 4'h0, 4'hF, 1'b1);
    wait_ack(100);
    tick(1);
    check("t3_an", an, 4'b1110);
    check("t3_seg", seg, 7'b1100000);
    check("t3_dp", dp, 1);
    tick(70);
    check("t3_ack_count", ack_cnt, 3);

    // Brightness and per-digit enable
    bright = 2'd1;
    wait_ft(100);
    count_frame();
    for (int k = 0; k < 4; k++) check("t4_bright1_lows", lows[k], 4);
    bright = 2'd0;
    wait_ft(100);
    count_frame();
    check("t4_bright0_lows", lows[0] + lows[1] + lows[2] + lows[3], 0);
    bright = 2'd3;
    do_load(16'hBBBB, 4'h0, 4'b0101, 1'b1);
    wait_ack(100);
    count_frame();
    check("t4_mode_an0", lows[0], 16);
    check("t4_mode_an1", lows[1], 0);
    check("t4_mode_an2", lows[2], 16);
    check("t4_mode_an3", lows[3], 0);

    // Reset mid-frame with a load pending
    tick(10);
    do_load(16'h1111, 4'h0, 4'hF, 1'b0);
    tick(5);
    rst = 1'b1;
    #1;
    check("t5_an", an, 4'hF);
    check("t5_seg", seg, 7'h7F);
    check("t5_dp", dp, 1);
    check("t5_ack", ack, 0);
    check("t5_tick", frame_tick, 0);
    tick(2);
    rst = 1'b0;
    tick(140);
    check("t5_no_ack", ack_cnt, 4);
    check("t5_dark", an, 4'hF);

    // Leading zeros
    do_load(16'h0050, 4'h0, 4'hF, 1'b1);
    wait_ack(200);
    for (int s = 0; s < 4; s++) begin
      tick(1);
      check("t6_an", an, t1_an[s]);
      check("t6_seg", seg, t6_seg[s]);
      check("t6_dp", dp, 1);
      tick(15);
    end

    check("final_queue_empty", exp_q.size(), 0);
    check("final_ack_count", ack_cnt, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
